// File: rtl/seq_mult_param_if.sv
// Handshake and operand/result bundle for seq_mult_param.
// The master drives operands and start; the slave returns busy/done/p.
interface seq_mult_param_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic [2*WIDTH-1:0]     p;
  logic                   done;

  modport master (
    output start, signed_mode, a, b,
    input  busy, p, done
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, p, done
  );
endinterface

// File: rtl/seq_mult_param.sv
// Shift-and-add sequential multiplier, signed or unsigned, with early exit
// once the remaining multiplier bits are zero. start/busy/done handshake.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_mult_param_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PW    = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_CALC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]       state_q,  state_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [PW-1:0]    mcand_q,  mcand_d;
  logic [PW-1:0]    p_q,      p_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             neg_q,    neg_d;
  logic             done_q,   done_d;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [PW-1:0]    acc_next;
  logic             last_iter;

  // Magnitudes are WIDTH-bit unsigned, so the most negative value maps exactly.
  always_comb begin
    abs_a = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    abs_b = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  end

  always_comb begin
    acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    last_iter = ((mplier_q >> 1) == '0) || (count_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    p_d      = p_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          acc_d    = '0;
          count_d  = '0;
          neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        if (last_iter) begin
          p_d     = neg_q ? -acc_next : acc_next;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q == S_CALC) || (state_q == S_DONE);
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: timing/arithmetic reference model
// compared every cycle, plus directed vectors with hand-computed results.
module tb_seq_mult_param;
  localparam int WIDTH = 8;
  localparam int PW    = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seq_mult_param_if #(.WIDTH(WIDTH)) bus ();

  seq_mult_param #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] ref_product(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic sm);
    longint sa, sb, prod;
    sa   = sm ? longint'($signed(a)) : longint'(a);
    sb   = sm ? longint'($signed(b)) : longint'(b);
    prod = sa * sb;
    return prod[PW-1:0];
  endfunction

  function automatic int ref_cycles(input logic [WIDTH-1:0] b, input logic sm);
    longint mag;
    int     n;
    mag = sm ? longint'($signed(b)) : longint'(b);
    if (mag < 0) mag = -mag;
    n = 0;
    while (mag != 0) begin
      n++;
      mag = mag >> 1;
    end
    return (n == 0) ? 1 : n;
  endfunction

  // Reference model: edge-indexed schedule of accept, done and free-again edges.
  int              e          = 0;
  int              done_edge  = -1;
  int              free_edge  = 0;
  logic [PW-1:0]   m_p        = '0;
  logic [PW-1:0]   m_pending  = '0;
  logic            m_busy     = 1'b0;
  logic            m_done     = 1'b0;

  initial begin : model
    int n;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        e = 0; done_edge = -1; free_edge = 0;
        m_p = '0; m_busy = 1'b0; m_done = 1'b0;
      end else begin
        e++;
        if (e >= free_edge && bus.start === 1'b1) begin
          n         = ref_cycles(bus.b, bus.signed_mode);
          m_pending = ref_product(bus.a, bus.b, bus.signed_mode);
          done_edge = e + n;
          free_edge = e + n + 2;
        end
        m_busy = (e <= done_edge);
        m_done = (e == done_edge);
        if (m_done) m_p = m_pending;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("cyc busy", PW'(bus.busy), PW'(m_busy));
        check("cyc done", PW'(bus.done), PW'(m_done));
        check("cyc p",    bus.p,         m_p);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic run(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic sm, input logic [PW-1:0] exp_p, input int exp_n);
    int cyc;
    bus.a = a; bus.b = b; bus.signed_mode = sm; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({name, " done seen"}, PW'(bus.done), PW'(1));
    check({name, " p"},         bus.p,         exp_p);
    check({name, " latency"},   PW'(cyc),      PW'(exp_n));
    @(negedge clk);
    check({name, " done width"}, PW'(bus.done), PW'(0));
    check({name, " busy after"}, PW'(bus.busy), PW'(0));
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
  endtask

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stim
    int cyc;
    int pulses;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset p",    bus.p,         '0);
    check("reset busy", PW'(bus.busy), PW'(0));
    check("reset done", PW'(bus.done), PW'(0));
    rst = 1'b0;
    @(negedge clk);

    run("u255x255",  8'd255, 8'd255, 1'b0, 16'hFE01, 8);
    run("s-3x5",     8'hFD,  8'd5,   1'b1, 16'hFFF1, 3);
    run("s-128x-128",8'h80,  8'h80,  1'b1, 16'h4000, 8);
    run("s-128x1",   8'h80,  8'h01,  1'b1, 16'hFF80, 1);
    run("uA5x0",     8'hA5,  8'h00,  1'b0, 16'h0000, 1);
    run("sA5x0",     8'hA5,  8'h00,  1'b1, 16'h0000, 1);
    run("u7x6",      8'd7,   8'd6,   1'b0, 16'd42,   3);
    run("s-1x-1",    8'hFF,  8'hFF,  1'b1, 16'h0001, 1);
    run("s5x-2",     8'd5,   8'hFE,  1'b1, 16'hFFF6, 2);

    // start held and operands scrambled throughout CALC and DONE
    bus.a = 8'd200; bus.b = 8'd100; bus.signed_mode = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.a = 8'd1; bus.b = 8'd1; bus.signed_mode = 1'b1;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("ignore p",       bus.p,    16'h4E20);
    check("ignore latency", PW'(cyc), PW'(7));
    bus.start = 1'b0;
    count_done(10, pulses);
    check("ignore no 2nd done", PW'(pulses), PW'(0));

    // asynchronous reset mid-CALC
    bus.a = 8'd200; bus.b = 8'd200; bus.signed_mode = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst p",    bus.p,         '0);
    check("async rst busy", PW'(bus.busy), PW'(0));
    check("async rst done", PW'(bus.done), PW'(0));
    @(negedge clk);
    rst = 1'b0;
    count_done(12, pulses);
    check("post rst no done", PW'(pulses), PW'(0));
    run("u12x12", 8'd12, 8'd12, 1'b0, 16'd144, 4);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
